// File: rtl/uart_rx_frame_chk_pkg.sv
// Shared UART definitions: parity-mode codes and the receive FSM state encoding.
// The bit sampler and the transmit path use the same codes.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Code 3 is reserved and behaves like "no parity".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter with a synchronous clear that takes priority over
// the increment. Used for the error-frame count and for overrun counters.
module uart_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins; otherwise count up and stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: assembles start, DATA_W data bits (LSB first),
// optional parity and one or two stop bits from per-bit samples, and reports
// the word with parity/stop/break status plus a saturating error count.
module uart_rx_frame_chk
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ZERO_ON_ERR = 1,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                bit_valid,
  input  logic                bit_in,
  input  logic [1:0]          parity_mode,
  input  logic                two_stop,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   data_out,
  output logic                frame_valid,
  output logic                parity_error,
  output logic                stop_bit_error,
  output logic                break_detect,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e state_q, state_d;

  // Per-frame working registers.
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_acc_q, par_acc_d;
  logic [1:0]        par_mode_q, par_mode_d;
  logic              two_stop_q, two_stop_d;
  logic              stop1_seen_q, stop1_seen_d;
  logic              par_err_q, par_err_d;
  logic              par_bit_q, par_bit_d;

  // Registered outputs.
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              frame_valid_q, frame_valid_d;
  logic              parity_error_q, parity_error_d;
  logic              stop_bit_error_q, stop_bit_error_d;
  logic              break_q, break_d;

  logic complete;
  logic stop_err;
  logic par_expected;
  logic err_inc;

  // State register; reset drops any partial frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the FSM moves only on a sample strobe.
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) state_d = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (!bit_in) begin
            state_d = ST_WAIT_HIGH;
          end else if (two_stop_q && !stop1_seen_q) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_HIGH: begin
          if (bit_in) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values: capture config, shift data, check parity and stop bits.
  always_comb begin
    bit_cnt_d        = bit_cnt_q;
    shift_d          = shift_q;
    par_acc_d        = par_acc_q;
    par_mode_d       = par_mode_q;
    two_stop_d       = two_stop_q;
    stop1_seen_d     = stop1_seen_q;
    par_err_d        = par_err_q;
    par_bit_d        = par_bit_q;
    data_out_d       = data_out_q;
    parity_error_d   = parity_error_q;
    stop_bit_error_d = stop_bit_error_q;
    break_d          = break_q;
    frame_valid_d    = 1'b0;
    complete         = 1'b0;
    stop_err         = 1'b0;
    par_expected     = (par_mode_q == PAR_ODD) ? ~par_acc_q : par_acc_q;

    if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            // Frame config is frozen here so mid-frame changes are ignored.
            par_mode_d   = parity_mode;
            two_stop_d   = two_stop;
            bit_cnt_d    = '0;
            par_acc_d    = 1'b0;
            stop1_seen_d = 1'b0;
            par_err_d    = 1'b0;
            par_bit_d    = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_in, shift_q[DATA_W-1:1]};
          par_acc_d = par_acc_q ^ bit_in;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        ST_PARITY: begin
          par_bit_d = bit_in;
          par_err_d = (bit_in != par_expected);
        end
        ST_STOP: begin
          if (bit_in && two_stop_q && !stop1_seen_q) begin
            stop1_seen_d = 1'b1;
          end else begin
            complete = 1'b1;
            stop_err = ~bit_in;
          end
        end
        default: ;
      endcase
    end

    if (complete) begin
      frame_valid_d    = 1'b1;
      parity_error_d   = par_err_q;
      stop_bit_error_d = stop_err;
      // Break means the line was low through the first stop bit, so a failing
      // second stop bit (first stop seen high) is not a break. The parity bit
      // register stays 0 when parity is disabled.
      break_d          = stop_err && !stop1_seen_q && (shift_q == '0) && !par_bit_q;
      data_out_d       = ((ZERO_ON_ERR != 0) && stop_err) ? '0 : shift_q;
    end
  end

  assign err_inc = complete && (par_err_q || stop_err);

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      par_acc_q        <= 1'b0;
      par_mode_q       <= PAR_NONE;
      two_stop_q       <= 1'b0;
      stop1_seen_q     <= 1'b0;
      par_err_q        <= 1'b0;
      par_bit_q        <= 1'b0;
      data_out_q       <= '0;
      frame_valid_q    <= 1'b0;
      parity_error_q   <= 1'b0;
      stop_bit_error_q <= 1'b0;
      break_q          <= 1'b0;
    end else begin
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      par_acc_q        <= par_acc_d;
      par_mode_q       <= par_mode_d;
      two_stop_q       <= two_stop_d;
      stop1_seen_q     <= stop1_seen_d;
      par_err_q        <= par_err_d;
      par_bit_q        <= par_bit_d;
      data_out_q       <= data_out_d;
      frame_valid_q    <= frame_valid_d;
      parity_error_q   <= parity_error_d;
      stop_bit_error_q <= stop_bit_error_d;
      break_q          <= break_d;
    end
  end

  uart_sat_counter #(
    .W(ERRCNT_W)
  ) u_err_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (err_inc),
    .clr_i   (err_clr),
    .count_o (err_count)
  );

  assign data_out       = data_out_q;
  assign frame_valid    = frame_valid_q;
  assign parity_error   = parity_error_q;
  assign stop_bit_error = stop_bit_error_q;
  assign break_detect   = break_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Bench for uart_rx_frame_chk: frames are built from fields into a symbol
// queue, the expected result of each frame is computed when it is built, and
// a negedge process compares two DUT instances (different ZERO_ON_ERR and
// counter widths) against the model every cycle.
module tb_uart_rx_frame_chk;

  typedef struct {
    bit       b;
    bit [1:0] pm;
    bit       ts;
    bit       clr;
    int       kind;   // 0 plain, 1 start bit, 2 frame-completing sample
    int       fidx;
  } sym_t;

  typedef struct {
    bit [7:0] data;
    bit       perr;
    bit       serr;
    bit       brk;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b1;
  logic [1:0] parity_mode = 2'd0;
  logic       two_stop = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] data0, data1;
  logic       fv0, fv1, perr0, perr1, serr0, serr1, brk0, brk1, busy0, busy1;
  logic [1:0] cnt0;
  logic [7:0] cnt1;

  uart_rx_frame_chk #(.DATA_W(8), .ZERO_ON_ERR(1), .ERRCNT_W(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .parity_mode(parity_mode), .two_stop(two_stop), .err_clr(err_clr),
    .data_out(data0), .frame_valid(fv0), .parity_error(perr0),
    .stop_bit_error(serr0), .break_detect(brk0), .err_count(cnt0), .busy(busy0)
  );

  uart_rx_frame_chk #(.DATA_W(8), .ZERO_ON_ERR(0), .ERRCNT_W(8)) dut1 (
    .clock(clock), .reset_n(reset_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .parity_mode(parity_mode), .two_stop(two_stop), .err_clr(err_clr),
    .data_out(data1), .frame_valid(fv1), .parity_error(perr1),
    .stop_bit_error(serr1), .break_detect(brk1), .err_count(cnt1), .busy(busy1)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int fv_cyc[$];

  sym_t   sq[$];
  frame_t fr[$];

  // Model state after the most recent strobe (m_*) and what the DUT shows now (exp_*).
  bit       m_fv, m_perr, m_serr, m_brk, m_busy, m_wait;
  bit [7:0] m_data0, m_data1;
  int       m_cnt0, m_cnt1;
  bit       exp_fv, exp_perr, exp_serr, exp_brk, exp_busy;
  bit [7:0] exp_data0, exp_data1;
  int       exp_cnt0, exp_cnt1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic int sat(input int v, input int w);
    return (v == (1 << w) - 1) ? v : v + 1;
  endfunction

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    cyc++;
    if (fv0 === 1'b1) fv_cyc.push_back(cyc);
    chk("frame_valid0", 32'(fv0), 32'(exp_fv));
    chk("frame_valid1", 32'(fv1), 32'(exp_fv));
    chk("parity_error0", 32'(perr0), 32'(exp_perr));
    chk("parity_error1", 32'(perr1), 32'(exp_perr));
    chk("stop_bit_error0", 32'(serr0), 32'(exp_serr));
    chk("stop_bit_error1", 32'(serr1), 32'(exp_serr));
    chk("break_detect0", 32'(brk0), 32'(exp_brk));
    chk("break_detect1", 32'(brk1), 32'(exp_brk));
    chk("busy0", 32'(busy0), 32'(exp_busy));
    chk("busy1", 32'(busy1), 32'(exp_busy));
    chk("data_out0", 32'(data0), 32'(exp_data0));
    chk("data_out1", 32'(data1), 32'(exp_data1));
    chk("err_count0", 32'(cnt0), 32'(exp_cnt0));
    chk("err_count1", 32'(cnt1), 32'(exp_cnt1));
  end

  task automatic model_clear();
    m_fv = 0; m_perr = 0; m_serr = 0; m_brk = 0; m_busy = 0; m_wait = 0;
    m_data0 = 0; m_data1 = 0; m_cnt0 = 0; m_cnt1 = 0;
    exp_fv = 0; exp_perr = 0; exp_serr = 0; exp_brk = 0; exp_busy = 0;
    exp_data0 = 0; exp_data1 = 0; exp_cnt0 = 0; exp_cnt1 = 0;
  endtask

  // Build one frame from its fields and record the outcome it must produce.
  task automatic gen_frame(input bit [7:0] data, input bit [1:0] pm, input bit ts,
                           input bit flip, input bit s1, input bit s2,
                           input int low_hold, input int gap, input bit clr_done);
    sym_t   s;
    frame_t f;
    bit     pen;
    bit     pb;
    pen = (pm == 2'd1) || (pm == 2'd2);
    f.data = data;
    f.perr = pen && flip;
    s.clr = 0; s.fidx = -1;
    s.b = 0; s.pm = pm; s.ts = ts; s.kind = 1;
    sq.push_back(s);
    s.kind = 0;
    for (int i = 0; i < 8; i++) begin
      s.b = data[i]; s.pm = 2'($urandom); s.ts = 1'($urandom);
      sq.push_back(s);
    end
    pb = 0;
    if (pen) begin
      pb = ((pm == 2'd1) ? (^data) : ~(^data)) ^ flip;
      s.b = pb;
      sq.push_back(s);
    end
    if (!s1) begin
      f.serr = 1;
      s.b = 0; s.kind = 2; s.clr = clr_done; s.fidx = fr.size();
      sq.push_back(s);
    end else if (ts) begin
      s.b = 1;
      sq.push_back(s);
      f.serr = !s2;
      s.b = s2; s.kind = 2; s.clr = clr_done; s.fidx = fr.size();
      sq.push_back(s);
    end else begin
      f.serr = 0;
      s.b = 1; s.kind = 2; s.clr = clr_done; s.fidx = fr.size();
      sq.push_back(s);
    end
    f.brk = f.serr && !s1 && (data == 8'h00) && !pb;
    fr.push_back(f);
    s.kind = 0; s.clr = 0; s.fidx = -1;
    if (f.serr) begin
      for (int i = 0; i < low_hold; i++) begin
        s.b = 0;
        sq.push_back(s);
      end
      s.b = 1;
      sq.push_back(s);
    end
    for (int i = 0; i < gap; i++) begin
      s.b = 1;
      sq.push_back(s);
    end
  endtask

  // One clock: publish the model's previous step, drive new inputs, advance the model.
  task automatic tick(input sym_t s, input bit v, input bit clr);
    frame_t f;
    bit     err_done;
    @(posedge clock);
    #1;
    exp_fv = m_fv; exp_perr = m_perr; exp_serr = m_serr; exp_brk = m_brk;
    exp_busy = m_busy; exp_data0 = m_data0; exp_data1 = m_data1;
    exp_cnt0 = m_cnt0; exp_cnt1 = m_cnt1;
    bit_valid   = v;
    bit_in      = v ? s.b : 1'($urandom);
    parity_mode = s.pm;
    two_stop    = s.ts;
    err_clr     = clr;
    m_fv = 0;
    err_done = 0;
    if (v) begin
      if (s.kind == 1) m_busy = 1;
      if (s.kind == 2) begin
        f = fr[s.fidx];
        m_fv = 1;
        m_perr = f.perr;
        m_serr = f.serr;
        m_brk = f.brk;
        m_data0 = f.serr ? 8'h00 : f.data;
        m_data1 = f.data;
        err_done = f.perr || f.serr;
        if (f.serr) m_wait = 1;
        else m_busy = 0;
      end
      if (s.kind == 0 && m_wait && s.b) begin
        m_wait = 0;
        m_busy = 0;
      end
    end
    if (clr) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else if (err_done) begin
      m_cnt0 = sat(m_cnt0, 2);
      m_cnt1 = sat(m_cnt1, 8);
    end
  endtask

  task automatic idle(input int n, input bit rnd_clr);
    sym_t s;
    s.b = 1; s.kind = 0; s.fidx = -1; s.clr = 0;
    for (int i = 0; i < n; i++) begin
      s.pm = 2'($urandom); s.ts = 1'($urandom);
      tick(s, 0, rnd_clr && ($urandom_range(19) == 0));
    end
  endtask

  task automatic drain(input int pct, input bit rnd_clr);
    sym_t s;
    while (sq.size() > 0) begin
      if (int'($urandom_range(99)) < pct) begin
        s = sq.pop_front();
        tick(s, 1, s.clr);
      end else begin
        idle(1, rnd_clr);
      end
    end
    idle(3, 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 0;
    bit_valid = 0;
    err_clr = 0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  initial begin
    int   c;
    sym_t s;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    idle(2, 0);

    // Reset state.
    chk("reset_data_out", 32'(data0), 32'h0);
    chk("reset_err_count", 32'(cnt1), 32'h0);
    chk("reset_busy", 32'(busy0), 32'h0);

    // 0xA5, no parity, one stop bit.
    gen_frame(8'hA5, 2'd0, 0, 0, 1, 1, 0, 1, 0);
    drain(100, 0);
    chk("a5_data", 32'(data0), 32'hA5);
    chk("a5_pulses", 32'(fv_cyc.size()), 32'd1);
    chk("a5_perr", 32'(perr0), 32'h0);
    chk("a5_serr", 32'(serr0), 32'h0);
    chk("a5_errcnt", 32'(cnt0), 32'h0);

    // Even parity, wrong then right parity bit on 0x03.
    gen_frame(8'h03, 2'd1, 0, 1, 1, 1, 0, 1, 0);
    drain(100, 0);
    chk("par_bad_perr", 32'(perr0), 32'h1);
    chk("par_bad_data", 32'(data0), 32'h03);
    chk("par_bad_cnt", 32'(cnt0), 32'h1);
    gen_frame(8'h03, 2'd1, 0, 0, 1, 1, 0, 1, 0);
    drain(100, 0);
    chk("par_ok_perr", 32'(perr0), 32'h0);

    // Two stop bits, second one low.
    gen_frame(8'h5A, 2'd0, 1, 0, 1, 0, 0, 1, 0);
    drain(100, 0);
    chk("stop2_serr", 32'(serr0), 32'h1);
    chk("stop2_data_zero", 32'(data0), 32'h00);
    chk("stop2_data_keep", 32'(data1), 32'h5A);

    // Break: 20 low strobes then a high sample.
    c = fv_cyc.size();
    gen_frame(8'h00, 2'd0, 0, 0, 0, 1, 10, 1, 0);
    drain(100, 0);
    chk("break_pulses", 32'(fv_cyc.size() - c), 32'd1);
    chk("break_brk", 32'(brk0), 32'h1);
    chk("break_serr", 32'(serr0), 32'h1);

    // Zero-gap back-to-back frames.
    c = fv_cyc.size();
    gen_frame(8'h11, 2'd0, 0, 0, 1, 1, 0, 0, 0);
    gen_frame(8'h22, 2'd0, 0, 0, 1, 1, 0, 1, 0);
    drain(100, 0);
    chk("b2b_pulses", 32'(fv_cyc.size() - c), 32'd2);
    if (fv_cyc.size() - c == 2) chk("b2b_spacing", 32'(fv_cyc[c+1] - fv_cyc[c]), 32'd10);
    chk("b2b_data", 32'(data0), 32'h22);

    // Reset during the 4th data bit.
    c = fv_cyc.size();
    gen_frame(8'h11, 2'd0, 0, 0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      s = sq.pop_front();
      tick(s, 1, 0);
    end
    sq.delete();
    do_reset();
    idle(3, 0);
    chk("rst_data", 32'(data0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_no_frame", 32'(fv_cyc.size() - c), 32'd0);

    // Counter saturation and clear-wins.
    idle(1, 0);
    s.b = 1; s.kind = 0; s.fidx = -1; s.clr = 0; s.pm = 0; s.ts = 0;
    tick(s, 0, 1);
    for (int i = 0; i < 5; i++) gen_frame(8'($urandom), 2'd0, 0, 0, 0, 1, 0, 1, 0);
    drain(100, 0);
    chk("cnt_sat", 32'(cnt0), 32'd3);
    chk("cnt_wide", 32'(cnt1), 32'd5);
    gen_frame(8'h77, 2'd0, 0, 0, 0, 1, 0, 1, 1);
    drain(100, 0);
    chk("cnt_clr_wins0", 32'(cnt0), 32'd0);
    chk("cnt_clr_wins1", 32'(cnt1), 32'd0);

    // Randomized frames with gaps, config churn and stray clears.
    for (int k = 0; k < 150; k++) begin
      gen_frame(($urandom_range(15) == 0) ? 8'h00 : 8'($urandom),
                2'($urandom_range(3)), 1'($urandom),
                $urandom_range(3) == 0, $urandom_range(7) != 0, $urandom_range(7) != 0,
                $urandom_range(3), $urandom_range(2), $urandom_range(9) == 0);
      drain(70, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_chk.md
# uart_rx_frame_chk

Parametrised UART receive frame checker, successor to the fixed 8-bit stop-bit checker. It consumes one mid-bit sample per `bit_valid` strobe from the receive bit sampler and assembles a complete frame: start bit, DATA_W data bits (LSB first), optional parity, and 1 or 2 stop bits. It reports the data word with start, parity, stop and break status, and keeps a saturating error-frame counter. It sits between the baud-rate sampler and the receive FIFO.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (legal 5..9).
- ZERO_ON_ERR, 1, when 1 `data_out` loads 0 on a stop-bit error (legacy behaviour); when 0 the received word always loads.
- ERRCNT_W, 8, width of the error-frame counter.

Ports (reset reset_n, asynchronous, active-low; clock clock):
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- bit_valid  in  1  one-cycle strobe; `bit_in` holds a valid line sample.
- bit_in  in  1  sampled RX line level.
- parity_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = reserved, treated as none.
- two_stop  in  1  1 = two stop bits expected.
- err_clr  in  1  synchronous clear of `err_count`.
- data_out  out  DATA_W  received word.
- frame_valid  out  1  one-cycle pulse; a frame has completed.
- parity_error  out  1  parity mismatch in the last frame.
- stop_bit_error  out  1  a stop bit sampled 0 in the last frame.
- break_detect  out  1  the last frame was all zeros, including parity and the first stop bit.
- err_count  out  ERRCNT_W  number of frames with any error; saturates at all-ones.
- busy  out  1  the FSM is not in IDLE.

## Operation
Reset values:
- All outputs are 0 and the FSM is in IDLE.

FSM states:
- IDLE, DATA, PARITY, STOP, WAIT_HIGH.

Transitions (all advance only on `bit_valid`):
- IDLE: `bit_in=0` is taken as a start bit → DATA. On this sample, latch `parity_mode` and `two_stop`, and clear the bit counter and the parity accumulator. `bit_in=1` stays in IDLE.
- DATA: shift `bit_in` into bit DATA_W-1 of the shift register, shifting right (LSB first). XOR it into the parity accumulator. After DATA_W samples → PARITY if parity is enabled, otherwise → STOP.
- PARITY: compare the received bit with the expected value. Even parity expects XOR(data). Odd parity expects ~XOR(data). Record a mismatch → STOP.
- STOP, sample = 1: if it is the first of two stop bits, stay in STOP. Otherwise complete the frame → IDLE.
- STOP, sample = 0: complete the frame immediately with a stop error; the second stop bit is not sampled. Go → WAIT_HIGH.
- WAIT_HIGH: stay until a sample of 1, then → IDLE. A line held low therefore never retriggers a start bit.

Frame completion (registered, single cycle):
- `frame_valid` = 1.
- `parity_error` and `stop_bit_error` are updated.
- `break_detect` = stop error AND all data bits 0 AND (parity bit 0, or parity disabled).
- `data_out` = received word. It is 0 instead when ZERO_ON_ERR=1 and there is a stop error.
- The status flags and `data_out` hold their values until the next completion.
- `err_count` increments when `parity_error` or `stop_bit_error` is set, and saturates at 2^ERRCNT_W-1.

Other rules:
- `err_clr` zeroes `err_count`. If `err_clr` coincides with an error completion, the clear wins.
- Changes to `parity_mode` and `two_stop` in mid-frame have no effect until the next start bit.
- The start bit is never rejected. Glitch filtering belongs to the sampler.

## Timing
- `frame_valid` asserts in the cycle after the `bit_valid` cycle that carries the final stop sample, or the failing stop sample.
- Total latency is 1 clock after the last stop sample.
- `bit_valid` may arrive on back-to-back cycles. The FSM takes exactly one sample per strobe, so there are no stalls and no back-pressure.
- A start bit may arrive on the very next strobe after completion. This is a zero-gap frame and is accepted.
- When `reset_n` is asserted in mid-frame, the FSM returns to IDLE immediately and all outputs clear. A partial frame produces no `frame_valid`.
- `busy` is high from the cycle after the start sample until the cycle in which the FSM re-enters IDLE.

## Structure
- `uart_pkg` holds:
  - the parity-mode localparams PAR_NONE, PAR_EVEN and PAR_ODD;
  - the FSM state encoding.
  - The sampler and future TX blocks share this package.
- One sub-module, `uart_sat_counter` (parameter W; inputs inc and clr, clr priority), implements `err_count` and is reusable for overrun counters.
- Parity calculation and the bit counter stay inline.

## Test plan
- DATA_W=8, no parity, one stop bit. Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → `data_out`=0xA5 and `frame_valid` pulses once, with no errors and `err_count`=0.
- Even parity. Send 0x03 with parity bit 1 → `parity_error`=1, `data_out`=0x03 and `err_count`=1. Then send the same data with parity 0 → `parity_error`=0.
- Two stop bits. Send 0x5A with stop samples 1 then 0 → `stop_bit_error`=1. `data_out`=0x00 when ZERO_ON_ERR=1, or 0x5A when ZERO_ON_ERR=0.
- Break. Hold the line at 0 for 20 strobes → exactly one `frame_valid` with `break_detect`=1 and `stop_bit_error`=1. No second frame occurs until a 1 is sampled.
- Back-to-back strobes and reset:
  - Two frames (0x11 then 0x22) with zero idle gap → two pulses, 10 cycles apart.
  - Assert `reset_n` in the 4th data bit → outputs return to 0 and there is no `frame_valid`.
- Counter. Set ERRCNT_W=2 and send 5 error frames → `err_count` saturates at 3. Assert `err_clr` together with a 6th error completion → `err_count`=0.
